// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the vector
// pipeline's read stages (r_mem_1, r_mem_2) and write stages (w_mem_2, w_mem_3).
// One access per cycle is granted. Reads are tracked through a MEM_LAT-deep
// pipeline so that read data returns to the requester that issued the read.
module dmem_port_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          stall,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gidx;
    logic             found;
    logic [IDX_W-1:0] cand;

    // Read-tracking pipeline: stage 0 holds a read granted last cycle, the
    // last stage lines up with mem_rdata for that read.
    logic [MEM_LAT-1:0] vld_p;
    logic [IDX_W-1:0]   own_p [MEM_LAT];

    // Round-robin search from ptr for the first valid requester; nothing is
    // granted while reset is asserted.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        gnt   = '0;
        if (!rst) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = IDX_W'((int'(ptr) + k) % N_REQ);
                if (!found && req_valid[cand]) begin
                    found = 1'b1;
                    gidx  = cand;
                end
            end
        end
        if (found) begin
            gnt[gidx] = 1'b1;
        end
    end

    // Steer the granted requester onto the memory port; all zero when idle.
    always_comb begin
        mem_en    = found;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (found) begin
            mem_we    = req_we[gidx];
            mem_addr  = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[int'(gidx)*DATA_W +: DATA_W];
        end
    end

    assign stall = req_valid & ~gnt;
    assign busy  = |vld_p;

    // Priority pointer and read-valid pipeline; both are cleared by reset so
    // reads in flight at reset never produce a response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            vld_p <= '0;
        end else begin
            if (found) begin
                ptr <= (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
            end
            vld_p[0] <= found & ~mem_we;
            for (int s = 1; s < MEM_LAT; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
        end
    end

    // Owner ids travel alongside the valid bits; they are only observed when
    // the matching valid bit is set, so they need no reset.
    always_ff @(posedge clk) begin
        own_p[0] <= gidx;
        for (int s = 1; s < MEM_LAT; s++) begin
            own_p[s] <= own_p[s-1];
        end
    end

    // Return read data to the owner of the read reaching the pipeline tail.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (vld_p[MEM_LAT-1]) begin
            rsp_valid[own_p[MEM_LAT-1]] = 1'b1;
            rsp_rdata                   = mem_rdata;
        end
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port vector data memory between the pipeline stages that issue memory operations: read stages 1/2 and write stages 2/3.
- Arbitrates round-robin, drives one memory access per cycle and stalls the losers.
- Tracks in-flight reads and returns read data to the owning requester after the fixed memory latency.
- Sits between CPU_vector's memory-stage request signals and the data memory.

Parameters:
- N_REQ, 4, number of requesters; index 0..3 = r_mem_1, r_mem_2, w_mem_2, w_mem_3
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from mem_en to mem_rdata valid (1..4)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  N_REQ  per-requester access request
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  packed write data
- gnt  out  N_REQ  one-hot grant, same cycle as the memory access
- stall  out  N_REQ  req_valid & ~gnt
- rsp_valid  out  N_REQ  one-hot read-data-valid
- rsp_rdata  out  DATA_W  read data, qualified by rsp_valid
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, MEM_LAT cycles after a read mem_en
- busy  out  1  any read in flight

Behaviour:

Clock and reset:
- One clock; reset is asynchronous and active-high on rst.
- During and after reset: priority pointer = 0, in-flight pipeline cleared.
- gnt, stall, rsp_valid, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, rsp_rdata = 0.

Grant logic (combinational):
- Round-robin starting at pointer ptr.
- Grant the first requester i with req_valid[i], searching ptr, ptr+1, … modulo N_REQ.
- At most one gnt bit set. gnt = 0 when no request is valid.

Memory drive (combinational from the granted requester):
- mem_en = |gnt; mem_we = req_we[g]; mem_addr = req_addr[g]; mem_wdata = req_wdata[g].
- All memory outputs are 0 when nothing is granted.

Pointer update (registered):
- On any grant to g, ptr <= (g+1) mod N_REQ. Unchanged when idle.

Stall and request rules:
- stall[i] = req_valid[i] & ~gnt[i].
- A stalled requester holds req_valid, req_we, req_addr and req_wdata stable until granted.
- Dropping a request before grant is legal; it is simply not serviced.

Read tracking:
- MEM_LAT-deep shift register of {valid, owner_id} entries.
- Entry pushed valid only for granted reads (mem_we = 0).
- At the tail: rsp_valid[owner] = 1 and rsp_rdata = mem_rdata in that same cycle, exactly MEM_LAT cycles after the grant.
- Back-to-back reads (one per cycle) are fully pipelined; responses return in grant order.

Writes:
- Complete at grant; no response.
- The write-after-read hazard belongs to the memory itself; the arbiter does not reorder.

Other outputs and edge cases:
- busy = OR of the pipeline valid bits.
- Fairness: under continuous requests from all N_REQ requesters, each is granted exactly once every N_REQ cycles. Worst-case wait is N_REQ-1 cycles.
- Single requester: granted every cycle, no stall.
- ptr wraps 3 -> 0.
- Reset mid-operation: in-flight reads discarded and no rsp_valid after reset deasserts. Requesters reissue.
- Simultaneous grant and response in the same cycle is normal and independent.

Test Plan:
- Reset then idle: rst pulse, no requests -> all outputs 0, busy 0, ptr 0; first grant goes to the lowest valid index.
- Single read: req_valid = 0001, req_we = 0, addr 0x10, mem returns 0xDEADBEEF -> gnt = 0001, mem_en = 1, mem_we = 0 at cycle t; rsp_valid = 0001, rsp_rdata = 0xDEADBEEF at t+2; busy high at t+1 and t+2.
- Full contention: req_valid = 1111 held for 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001, …; stall always equals req_valid & ~gnt.
- Write priority wrap: ptr = 3 via a prior grant to 2, then req_valid = 1001, req 3 write addr 0x20 data 0x55 -> gnt = 1000, mem_we = 1, mem_wdata = 0x55; next cycle gnt = 0001; no rsp_valid for the write.
- Pipelined reads: requesters 0 and 1 read 0x0 and 0x4 on consecutive cycles, memory returns 0xA then 0xB -> rsp_valid 0001 with 0xA, then 0010 with 0xB, on consecutive cycles.
- Reset mid-flight: grant read, assert rst the next cycle for 1 cycle -> no rsp_valid ever appears; busy = 0 after reset; a new read after reset completes normally.
